// File: rtl/axi_burst_arbiter.sv
// Round-robin arbiter that shares one DDR3 AXI burst engine between the
// frame-buffer write-burst and read-burst requesters. One complete burst is
// granted at a time. The grant is held until the engine reports cmd_done, or
// until the burst is aborted on timeout. Zero-length requests are acknowledged
// without issuing a command.
module axi_burst_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 10,
    parameter int TIMEOUT_CYC = 4096,
    parameter int WR_FIRST    = 1
) (
    input  logic              ui_clk,
    input  logic              ui_rst_n,
    input  logic              init_calib_complete,
    input  logic              wr_burst_req,
    input  logic [ADDR_W-1:0] wr_burst_addr,
    input  logic [LEN_W-1:0]  wr_burst_len,
    output logic              wr_ready,
    output logic              wr_burst_finish,
    input  logic              rd_burst_req,
    input  logic [ADDR_W-1:0] rd_burst_addr,
    input  logic [LEN_W-1:0]  rd_burst_len,
    output logic              rd_ready,
    output logic              rd_burst_finish,
    output logic              cmd_valid,
    output logic              cmd_rw,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic              timeout_err,
    output logic              len_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        ZL_ACK
    } state_e;

    localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    logic              last_rd_q, last_rd_d;   // 1: the most recent grant went to read
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_rw_q, cmd_rw_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
    logic              wr_fin_q, wr_fin_d;
    logic              rd_fin_q, rd_fin_d;
    logic              timeout_err_q, timeout_err_d;
    logic              len_err_q, len_err_d;

    logic              accept;
    logic              grant_rd;
    logic [LEN_W-1:0]  grant_len;

    // Requests are only looked at while idle and the DDR is calibrated.
    assign accept = (state_q == IDLE) && init_calib_complete;

    // Next-state and datapath decisions for the grant / issue / wait sequence.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        last_rd_d     = last_rd_q;
        cnt_d         = cnt_q;
        cmd_rw_d      = cmd_rw_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_len_d     = cmd_len_q;
        wr_fin_d      = 1'b0;
        rd_fin_d      = 1'b0;
        timeout_err_d = timeout_err_q;
        len_err_d     = len_err_q;
        // A lone requester wins; with both high, the side not served last time wins.
        grant_rd      = rd_burst_req && (!wr_burst_req || !last_rd_q);
        grant_len     = grant_rd ? rd_burst_len : wr_burst_len;

        case (state_q)
            IDLE: begin
                if (accept && (wr_burst_req || rd_burst_req)) begin
                    last_rd_d  = grant_rd;
                    cmd_rw_d   = grant_rd;
                    cmd_addr_d = grant_rd ? rd_burst_addr : wr_burst_addr;
                    cmd_len_d  = grant_len;
                    cnt_d      = '0;
                    if (grant_len == '0) begin
                        len_err_d = 1'b1;
                        state_d   = ZL_ACK;
                    end else begin
                        state_d = grant_rd ? RD_ISSUE : WR_ISSUE;
                    end
                end
            end
            WR_ISSUE, RD_ISSUE: begin
                if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cmd_ready) begin
                        state_d = (state_q == RD_ISSUE) ? RD_WAIT : WR_WAIT;
                    end
                end
            end
            WR_WAIT, RD_WAIT: begin
                if (cmd_done) begin
                    wr_fin_d = (state_q == WR_WAIT);
                    rd_fin_d = (state_q == RD_WAIT);
                    state_d  = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ZL_ACK: begin
                // Finish is still pulsed so the requester advances its address.
                wr_fin_d = !cmd_rw_q;
                rd_fin_d = cmd_rw_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset drops any burst in flight.
    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            state_q       <= IDLE;
            last_rd_q     <= (WR_FIRST != 0);
            cnt_q         <= '0;
            cmd_rw_q      <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_len_q     <= '0;
            wr_fin_q      <= 1'b0;
            rd_fin_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before the edge, regardless of statement order.
            state_q       <= state_d;
            last_rd_q     <= last_rd_d;
            cnt_q         <= cnt_d;
            cmd_rw_q      <= cmd_rw_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_len_q     <= cmd_len_d;
            wr_fin_q      <= wr_fin_d;
            rd_fin_q      <= rd_fin_d;
            timeout_err_q <= timeout_err_d;
            len_err_q     <= len_err_d;
        end
    end

    assign wr_ready        = accept;
    assign rd_ready        = accept;
    assign cmd_valid       = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
    assign cmd_rw          = cmd_rw_q;
    assign cmd_addr        = cmd_addr_q;
    assign cmd_len         = cmd_len_q;
    assign wr_burst_finish = wr_fin_q;
    assign rd_burst_finish = rd_fin_q;
    assign timeout_err     = timeout_err_q;
    assign len_err         = len_err_q;

endmodule
